// File: rtl/fma_dot_sequencer_pkg.sv
// fma_dot_sequencer_pkg: shared FSM encoding and FP constants for the dot-product sequencer
package fma_dot_sequencer_pkg;

    localparam int PARM_EXP  = 8;
    localparam int PARM_MANT = 23;

    localparam logic [1+PARM_EXP+PARM_MANT-1:0] FP_POS_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fma_dot_sequencer_watchdog.sv
// fma_watchdog: clear/enable cycle counter flagging the cycle the count reaches TIMEOUT
module fma_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // count enabled cycles since the last clear, saturating at TIMEOUT
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            count <= '0;
        else if (clr_i)
            count <= '0;
        else if (en_i && count != CW'(TIMEOUT))
            count <= count + 1'b1;
    end

    assign expired_o = en_i && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fma_dot_sequencer.sv
// fma_dot_sequencer: drives one shared FMA pipe through a serial dot product acc += b*c
module fma_dot_sequencer
    import fma_dot_sequencer_pkg::*;
#(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int LEN_W     = 8,
    parameter int TIMEOUT   = 16,
    localparam int W        = 1 + PARM_EXP + PARM_MANT
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [W-1:0]     op_b_i,
    input  logic [W-1:0]     op_c_i,
    output logic             fma_valid_o,
    output logic [W-1:0]     fma_a_o,
    output logic [W-1:0]     fma_b_o,
    output logic [W-1:0]     fma_c_o,
    input  logic             fma_res_valid_i,
    input  logic [W-1:0]     fma_res_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [W-1:0]     res_o,
    output logic             res_err_o
);

    state_t           state, state_d;
    logic [W-1:0]     acc;
    logic [LEN_W-1:0] cnt, len_q;
    logic             err;
    logic             issue_hs;
    logic             expired;

    assign op_ready_o = (state == ISSUE);
    assign issue_hs   = op_ready_o && op_valid_i;
    assign res_o      = acc;
    assign res_err_o  = err;

    fma_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (issue_hs),
        .en_i      (state == WAIT),
        .expired_o (expired)
    );

    // state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state <= IDLE;
        else
            state <= state_d;
    end

    // next state; a result arriving with the timeout takes priority
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start_i ? ((len_i == '0) ? DONE : ISSUE) : IDLE;
            ISSUE:   state_d = op_valid_i ? WAIT : ISSUE;
            WAIT:    state_d = fma_res_valid_i ? ((cnt == len_q) ? DONE : ISSUE) : (expired ? DONE : WAIT);
            DONE:    state_d = res_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // operand/result registers, element counter and registered status outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc         <= W'(FP_POS_ZERO);
            cnt         <= '0;
            len_q       <= '0;
            err         <= 1'b0;
            fma_valid_o <= 1'b0;
            fma_a_o     <= '0;
            fma_b_o     <= '0;
            fma_c_o     <= '0;
            busy_o      <= 1'b0;
            res_valid_o <= 1'b0;
        end else begin
            fma_valid_o <= issue_hs;
            busy_o      <= (state_d != IDLE);
            res_valid_o <= (state_d == DONE);
            if (state == IDLE && start_i) begin
                len_q <= len_i;
                acc   <= W'(FP_POS_ZERO);
                cnt   <= '0;
            end
            if (issue_hs) begin
                fma_a_o <= acc;
                fma_b_o <= op_b_i;
                fma_c_o <= op_c_i;
                cnt     <= cnt + 1'b1;
            end
            if (state == WAIT && fma_res_valid_i)
                acc <= fma_res_i;
            if (state == WAIT && !fma_res_valid_i && expired)
                err <= 1'b1;
            if (state == DONE && res_ready_i)
                err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// tb_fma_dot_sequencer: directed scoreboard bench with a fixed-latency FMA responder
module tb_fma_dot_sequencer;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  len_i = '0;
    logic        busy_o;
    logic        op_valid_i = 1'b0;
    logic        op_ready_o;
    logic [31:0] op_b_i = '0, op_c_i = '0;
    logic        fma_valid_o;
    logic [31:0] fma_a_o, fma_b_o, fma_c_o;
    logic        fma_res_valid_i;
    logic [31:0] fma_res_i;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [31:0] res_o;
    logic        res_err_o;

    logic        model_rv = 1'b0, spur_rv = 1'b0;
    logic [31:0] model_res = '0, spur_res = '0, pend = '0;
    int          cd = 0;

    assign fma_res_valid_i = model_rv | spur_rv;
    assign fma_res_i       = spur_rv ? spur_res : model_res;

    always #5 clk = ~clk;

    fma_dot_sequencer dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .len_i(len_i), .busy_o(busy_o),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_b_i(op_b_i), .op_c_i(op_c_i),
        .fma_valid_o(fma_valid_o), .fma_a_o(fma_a_o), .fma_b_o(fma_b_o), .fma_c_o(fma_c_o),
        .fma_res_valid_i(fma_res_valid_i), .fma_res_i(fma_res_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o), .res_err_o(res_err_o)
    );

    typedef struct {
        logic [31:0] a, b, c;
    } iss_t;

    iss_t        exp_iss[$];
    logic [32:0] exp_res[$];
    logic [32:0] ret_q[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, last_iss_cyc = 0, chk_lat = -1, n_iss = 0;
    logic        rv_prev = 1'b0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // issue monitor: every fma_valid_o pulse must match the next expected operand triple
    always @(negedge clk) begin
        if (fma_valid_o) begin
            n_iss++;
            last_iss_cyc = cyc;
            if (exp_iss.size() == 0)
                chk1("issue_unexpected", fma_valid_o, 1'b0);
            else begin
                iss_t e;
                e = exp_iss.pop_front();
                chk32("fma_a", fma_a_o, e.a);
                chk32("fma_b", fma_b_o, e.b);
                chk32("fma_c", fma_c_o, e.c);
            end
        end
    end

    // result monitor: each rising res_valid_o is compared with the next expected sum/error
    always @(negedge clk) begin
        if (res_valid_o && !rv_prev) begin
            if (exp_res.size() == 0)
                chk1("res_unexpected", res_valid_o, 1'b0);
            else begin
                logic [32:0] e;
                e = exp_res.pop_front();
                chk32("res_o", res_o, e[31:0]);
                chk1("res_err", res_err_o, e[32]);
                if (chk_lat >= 0)
                    chk32("timeout_latency", 32'(cyc - last_iss_cyc), 32'(chk_lat));
            end
        end
        rv_prev = res_valid_o;
    end

    // FMA model: fixed latency, may drop a result when its entry is flagged
    always @(negedge clk) begin
        model_rv = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                model_rv  = 1'b1;
                model_res = pend;
            end
        end
        if (fma_valid_o && ret_q.size() > 0) begin
            logic [32:0] r;
            r = ret_q.pop_front();
            if (!r[32]) begin
                cd   = LAT;
                pend = r[31:0];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_run(input logic [7:0] n);
        start_i = 1'b1;
        len_i   = n;
        step();
        start_i = 1'b0;
    endtask

    task automatic send_op(input logic [31:0] b, input logic [31:0] c);
        int n = 0;
        op_valid_i = 1'b1;
        op_b_i     = b;
        op_c_i     = c;
        while (!op_ready_o && n < 60) begin
            step();
            n++;
        end
        if (n == 60) chk1("op_ready_timeout", op_ready_o, 1'b1);
        step();
        op_valid_i = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!res_valid_o && n < 100) begin
            step();
            n++;
        end
        chk1("res_valid_wait", res_valid_o, 1'b1);
    endtask

    task automatic accept();
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        chk1("busy_after_accept", busy_o, 1'b0);
    endtask

    task automatic push_iss(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        iss_t e;
        e.a = a;
        e.b = b;
        e.c = c;
        exp_iss.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n0;
        // reset state
        repeat (3) step();
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_op_ready", op_ready_o, 1'b0);
        chk1("rst_fma_valid", fma_valid_o, 1'b0);
        chk1("rst_res_valid", res_valid_o, 1'b0);
        chk32("rst_res", res_o, 32'h0);
        chk1("rst_err", res_err_o, 1'b0);
        rst_n_i = 1'b1;
        step();

        // dot of 2: 1*2 + 3*1 = 5
        push_iss(32'h0, 32'h3F800000, 32'h40000000);
        push_iss(32'h40000000, 32'h40400000, 32'h3F800000);
        ret_q.push_back({1'b0, 32'h40000000});
        ret_q.push_back({1'b0, 32'h40A00000});
        exp_res.push_back({1'b0, 32'h40A00000});
        start_run(8'd2);
        chk1("busy_running", busy_o, 1'b1);
        send_op(32'h3F800000, 32'h40000000);
        send_op(32'h40400000, 32'h3F800000);
        wait_valid();
        accept();

        // zero length: result right after start, no issue
        exp_res.push_back({1'b0, 32'h0});
        n0 = n_iss;
        start_run(8'd0);
        chk1("len0_res_valid", res_valid_o, 1'b1);
        accept();
        chk32("len0_no_issue", 32'(n_iss), 32'(n0));

        // backpressure on both streams: 2*3 = 6
        push_iss(32'h0, 32'h40000000, 32'h40400000);
        ret_q.push_back({1'b0, 32'h40C00000});
        exp_res.push_back({1'b0, 32'h40C00000});
        start_run(8'd1);
        n0 = n_iss;
        repeat (5) begin
            step();
            chk1("gap_op_ready", op_ready_o, 1'b1);
            chk32("gap_no_issue", 32'(n_iss), 32'(n0));
        end
        send_op(32'h40000000, 32'h40400000);
        wait_valid();
        repeat (4) begin
            step();
            chk1("hold_res_valid", res_valid_o, 1'b1);
            chk32("hold_res", res_o, 32'h40C00000);
        end
        accept();
        chk1("bp_res_valid_drop", res_valid_o, 1'b0);

        // timeout: second result dropped, partial sum 1.0 returned with error
        push_iss(32'h0, 32'h3F800000, 32'h3F800000);
        push_iss(32'h3F800000, 32'h40000000, 32'h40000000);
        ret_q.push_back({1'b0, 32'h3F800000});
        ret_q.push_back({1'b1, 32'h0});
        exp_res.push_back({1'b1, 32'h3F800000});
        chk_lat = 16;
        start_run(8'd2);
        send_op(32'h3F800000, 32'h3F800000);
        send_op(32'h40000000, 32'h40000000);
        wait_valid();
        accept();
        chk_lat = -1;
        chk1("err_cleared", res_err_o, 1'b0);

        // spurious result in IDLE/ISSUE and start in WAIT: 2*1 + 1*1 = 3
        spur_res = 32'hDEADBEEF;
        spur_rv  = 1'b1;
        step();
        spur_rv  = 1'b0;
        chk1("spur_idle_busy", busy_o, 1'b0);
        push_iss(32'h0, 32'h40000000, 32'h3F800000);
        push_iss(32'h40000000, 32'h3F800000, 32'h3F800000);
        ret_q.push_back({1'b0, 32'h40000000});
        ret_q.push_back({1'b0, 32'h40400000});
        exp_res.push_back({1'b0, 32'h40400000});
        start_run(8'd2);
        spur_rv = 1'b1;
        step();
        spur_rv = 1'b0;
        chk1("spur_issue_state", op_ready_o, 1'b1);
        send_op(32'h40000000, 32'h3F800000);
        start_i = 1'b1;
        len_i   = 8'd7;
        step();
        start_i = 1'b0;
        chk1("start_in_wait_ignored", op_ready_o, 1'b0);
        send_op(32'h3F800000, 32'h3F800000);
        wait_valid();
        accept();

        // reset in WAIT with N=4; late result must be ignored
        push_iss(32'h0, 32'h40400000, 32'h40400000);
        ret_q.push_back({1'b0, 32'h41100000});
        ret_q.push_back({1'b0, 32'h41100000});
        start_run(8'd4);
        send_op(32'h40400000, 32'h40400000);
        @(negedge clk);
        #1;
        rst_n_i = 1'b0;
        #1;
        chk1("mid_rst_busy", busy_o, 1'b0);
        chk1("mid_rst_fma_valid", fma_valid_o, 1'b0);
        chk1("mid_rst_res_valid", res_valid_o, 1'b0);
        chk32("mid_rst_fma_b", fma_b_o, 32'h0);
        chk32("mid_rst_res", res_o, 32'h0);
        ret_q.delete();
        exp_iss.delete();
        step();
        step();
        rst_n_i = 1'b1;
        repeat (4) step();
        chk1("late_res_ignored_busy", busy_o, 1'b0);
        chk32("late_res_ignored_acc", res_o, 32'h0);
        push_iss(32'h0, 32'h40800000, 32'h3F800000);
        ret_q.push_back({1'b0, 32'h40800000});
        exp_res.push_back({1'b0, 32'h40800000});
        start_run(8'd1);
        send_op(32'h40800000, 32'h3F800000);
        wait_valid();
        accept();

        repeat (3) step();
        chk32("iss_left", 32'(exp_iss.size()), 32'h0);
        chk32("res_left", 32'(exp_res.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
